// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and helpers for the 4-way round-robin select-path arbiter.
package mux4_rr_arbiter_pkg;

    localparam int NUM_SRC = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    function automatic logic [NUM_SRC-1:0] onehot2(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational 4-way round-robin pick: first set request scanning from ptr upward, mod 4.
module rr_pick4
    import mux4_rr_arbiter_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [1:0]         ptr,
    output logic               any,
    output logic [1:0]         idx
);

    logic [1:0] cand;

    // Scan from the farthest offset down so the nearest set bit to ptr is the last to win.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        any  = 1'b0;
        idx  = 2'd0;
        cand = 2'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            cand = ptr + 2'(i);
            if (req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for the shared 4-input select path: grants, captures the winner's word,
// presents it with valid/ready, acks the winner on handshake and aborts stalled grants.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] req,
    input  logic [WIDTH-1:0]   n0,
    input  logic [WIDTH-1:0]   n1,
    input  logic [WIDTH-1:0]   n2,
    input  logic [WIDTH-1:0]   n3,
    output logic [1:0]         sel,
    output logic [NUM_SRC-1:0] gnt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [NUM_SRC-1:0] ack,
    output logic               timeout_err
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e             state_q;
    logic [1:0]         sel_q;
    logic [1:0]         ptr_q;
    logic [NUM_SRC-1:0] gnt_q;
    logic               out_valid_q;
    logic [WIDTH-1:0]   out_data_q;
    logic               timeout_err_q;
    logic [CW-1:0]      count_q;

    logic               handshake;
    logic               timeout_hit;
    logic [NUM_SRC-1:0] pick_req;
    logic [1:0]         pick_ptr;
    logic               pick_any;
    logic [1:0]         pick_idx;
    logic [WIDTH-1:0]   pick_data;

    assign handshake   = (state_q == BUSY) && out_valid_q && out_ready;
    assign timeout_hit = (TIMEOUT != 0) && (count_q == CW'(TIMEOUT - 1));

    // While busy, the current winner is excluded and priority starts just past it,
    // so a handshake can re-arbitrate in the same edge as if ptr had already moved.
    assign pick_req = (state_q == BUSY) ? (req & ~gnt_q) : req;
    assign pick_ptr = (state_q == BUSY) ? (sel_q + 2'd1) : ptr_q;

    rr_pick4 u_pick (
        .req (pick_req),
        .ptr (pick_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_comb begin
        case (pick_idx)
            2'd0:    pick_data = n0;
            2'd1:    pick_data = n1;
            2'd2:    pick_data = n2;
            default: pick_data = n3;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
        if (rst) begin
            state_q       <= IDLE;
            sel_q         <= 2'd0;
            ptr_q         <= 2'd0;
            gnt_q         <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            timeout_err_q <= 1'b0;
            count_q       <= '0;
        end else begin
            timeout_err_q <= 1'b0;
            if (state_q == IDLE || handshake) begin
                if (handshake) ptr_q <= sel_q + 2'd1;
                if (pick_any) begin
                    state_q     <= BUSY;
                    sel_q       <= pick_idx;
                    gnt_q       <= onehot2(pick_idx);
                    out_data_q  <= pick_data;
                    out_valid_q <= 1'b1;
                    count_q     <= '0;
                end else begin
                    state_q     <= IDLE;
                    gnt_q       <= '0;
                    out_valid_q <= 1'b0;
                end
            end else if (timeout_hit) begin
                state_q       <= IDLE;
                gnt_q         <= '0;
                out_valid_q   <= 1'b0;
                timeout_err_q <= 1'b1;
                ptr_q         <= sel_q + 2'd1;
            end else begin
                count_q <= count_q + CW'(1);
            end
        end
    end

    assign sel         = sel_q;
    assign gnt         = gnt_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign timeout_err = timeout_err_q;
    assign ack         = handshake ? gnt_q : '0;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: inputs change and outputs are sampled on the falling edge.
module tb_mux4_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] n0, n1, n2, n3;
    logic [1:0]  sel;
    logic [3:0]  gnt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  ack;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;

    mux4_rr_arbiter #(.WIDTH(32), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .n0          (n0),
        .n1          (n1),
        .n2          (n2),
        .n3          (n3),
        .sel         (sel),
        .gnt         (gnt),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .ack         (ack),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".valid"}, 32'(out_valid), 32'd0);
        check({tag, ".gnt"},   32'(gnt),       32'd0);
        check({tag, ".ack"},   32'(ack),       32'd0);
        check({tag, ".err"},   32'(timeout_err), 32'd0);
    endtask

    task automatic check_grant(input string tag, input logic [1:0] w, input logic [31:0] data,
                               input logic exp_ack);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".sel"},   32'(sel),       32'(w));
        check({tag, ".gnt"},   32'(gnt),       32'(4'b0001 << w));
        check({tag, ".data"},  out_data,       data);
        check({tag, ".ack"},   32'(ack),       exp_ack ? 32'(4'b0001 << w) : 32'd0);
    endtask

    initial begin
        logic [1:0] exp_w;

        rst = 1'b1; req = 4'b0000; out_ready = 1'b0;
        n0 = 32'h0; n1 = 32'h0; n2 = 32'h0; n3 = 32'h0;
        tick();
        tick();
        check_idle("reset");
        check("reset.sel",  32'(sel), 32'd0);
        check("reset.data", out_data, 32'd0);

        // single request from source 0, consumer ready
        rst = 1'b0; req = 4'b0001; n0 = 32'hA5A5_0000; out_ready = 1'b1;
        n1 = 32'h1111_1111; n2 = 32'h2222_2222; n3 = 32'h3333_3333;
        tick();
        check_grant("t1", 2'd0, 32'hA5A5_0000, 1'b1);
        req = 4'b0000;
        tick();
        check_idle("t1.after");
        check("t1.sel_hold", 32'(sel), 32'd0);

        // ptr=1, all requesting: 1,2,3,0,1 back to back
        req = 4'b1111;
        exp_w = 2'd1;
        for (int k = 0; k < 5; k++) begin
            tick();
            case (exp_w)
                2'd0:    check_grant("t2", exp_w, 32'hA5A5_0000, 1'b1);
                2'd1:    check_grant("t2", exp_w, 32'h1111_1111, 1'b1);
                2'd2:    check_grant("t2", exp_w, 32'h2222_2222, 1'b1);
                default: check_grant("t2", exp_w, 32'h3333_3333, 1'b1);
            endcase
            exp_w = exp_w + 2'd1;
        end
        req = 4'b0000;
        tick();
        check_idle("t2.after");
        check("t2.sel_hold", 32'(sel), 32'd1);

        // stalled consumer: captured word must not follow n2
        req = 4'b0100; n2 = 32'h0000_1234; out_ready = 1'b0;
        tick();
        check_grant("t3.grant", 2'd2, 32'h0000_1234, 1'b0);
        n2 = 32'hFFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_grant("t3.stall", 2'd2, 32'h0000_1234, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        check("t3.ack", 32'(ack), 32'h4);
        check("t3.data", out_data, 32'h0000_1234);
        tick();
        req = 4'b0000;
        check_idle("t3.after");
        check("t3.sel_hold", 32'(sel), 32'd2);

        // watchdog abort of source 3
        req = 4'b1000; out_ready = 1'b0;
        tick();
        check_grant("t4.grant", 2'd3, 32'h3333_3333, 1'b0);
        for (int k = 1; k < 16; k++) begin
            tick();
            check("t4.wait.err",   32'(timeout_err), 32'd0);
            check("t4.wait.valid", 32'(out_valid),   32'd1);
        end
        tick();
        check("t4.err",   32'(timeout_err), 32'd1);
        check("t4.valid", 32'(out_valid),   32'd0);
        check("t4.gnt",   32'(gnt),         32'd0);
        check("t4.ack",   32'(ack),         32'd0);
        req = 4'b1001;
        tick();
        check_grant("t4.next", 2'd0, 32'hA5A5_0000, 1'b0);
        check("t4.err_pulse", 32'(timeout_err), 32'd0);

        // handshake lands in the same cycle the watchdog would fire
        for (int k = 1; k < 16; k++) begin
            tick();
            check("t5.wait.err", 32'(timeout_err), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("t5.ack", 32'(ack), 32'h1);
        tick();
        check("t5.err", 32'(timeout_err), 32'd0);
        check_grant("t5.next", 2'd3, 32'h3333_3333, 1'b1);

        // reset while busy
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("t6.pre_ack", 32'(ack), 32'd0);
        tick();
        out_ready = 1'b1;
        #1;
        check_idle("t6.reset");
        check("t6.sel",  32'(sel), 32'd0);
        check("t6.data", out_data, 32'd0);
        rst = 1'b0; req = 4'b0010;
        tick();
        check_grant("t6.after", 2'd1, 32'h1111_1111, 1'b1);
        req = 4'b0000;
        tick();
        check_idle("t6.end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
